// File: rtl/pic_inta_sequencer.sv
// 8259A-style interrupt-acknowledge sequencer: priority resolve, INT/INTA handshake, ISR and OCW2 EOI/rotation.
// Optional feature macro: PIC_ROTATE_EN (priority rotation; prio_base is tied to 0 when undefined).
module pic_inta_sequencer #(
    parameter int unsigned NUM_IR     = 8,
    parameter logic [2:0]  SPUR_LEVEL = 3'd7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] irq_pend,
    input  logic              inta_pulse,
    input  logic              aeoi_mode,
    input  logic [4:0]        vec_base,
    input  logic              ocw2_valid,
    input  logic [2:0]        ocw2_cmd,
    input  logic [2:0]        ocw2_level,
    output logic              int_out,
    output logic [NUM_IR-1:0] irr_clear,
    output logic [NUM_IR-1:0] isr,
    output logic [7:0]        vector,
    output logic              vector_valid,
    output logic [2:0]        prio_base
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK1} state_t;

    state_t      state_q, state_d;
    logic        int_out_q, int_out_d;
    logic [7:0]  irr_clear_q, irr_clear_d;
    logic [7:0]  isr_q, isr_d;
    logic [7:0]  vector_q, vector_d;
    logic        vector_valid_q, vector_valid_d;
    logic [2:0]  lvl_q, lvl_d;
    logic        spur_q, spur_d;
    logic [2:0]  base;

    logic [7:0]  rot_pend, rot_isr;
    logic [3:0]  pend_hit, isr_hit;
    logic        elig;
    logic [2:0]  win_lvl, hp_isr_lvl;
    logic [7:0]  set_mask, aeoi_clr, ocw_clr;

`ifdef PIC_ROTATE_EN
    logic [2:0]  prio_base_q, prio_base_d;
    logic        rot_aeoi_q, rot_aeoi_d;
    assign base = prio_base_q;
`else
    assign base = '0;
`endif

    // Returns {found, index} of the lowest set bit.
    function automatic logic [3:0] lowest_set(input logic [7:0] v);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[7-i]) r = {1'b1, 3'(7 - i)};
        end
        return r;
    endfunction

    // Rotate so that bit position equals rank relative to prio_base.
    always_comb begin
        rot_pend = '0;
        rot_isr  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            rot_pend[i] = irq_pend[base + 3'(i)];
            rot_isr[i]  = isr_q[base + 3'(i)];
        end
        pend_hit   = lowest_set(rot_pend);
        isr_hit    = lowest_set(rot_isr);
        elig       = pend_hit[3] && (!isr_hit[3] || (pend_hit[2:0] < isr_hit[2:0]));
        win_lvl    = pend_hit[2:0] + base;
        hp_isr_lvl = isr_hit[2:0] + base;
    end

    always_comb begin
        state_d        = state_q;
        int_out_d      = int_out_q;
        irr_clear_d    = '0;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
        lvl_d          = lvl_q;
        spur_d         = spur_q;
        set_mask       = '0;
        aeoi_clr       = '0;
        ocw_clr        = '0;
`ifdef PIC_ROTATE_EN
        prio_base_d    = prio_base_q;
        rot_aeoi_d     = rot_aeoi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (elig) begin
                    int_out_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (inta_pulse) begin
                    int_out_d = 1'b0;
                    state_d   = S_ACK1;
                    if (elig) begin
                        lvl_d             = win_lvl;
                        spur_d            = 1'b0;
                        set_mask[win_lvl] = 1'b1;
                        irr_clear_d       = set_mask;
                    end else begin
                        lvl_d  = SPUR_LEVEL;
                        spur_d = 1'b1;
                    end
                end else if (!elig) begin
                    int_out_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_ACK1: begin
                if (inta_pulse) begin
                    vector_d       = {vec_base, lvl_q};
                    vector_valid_d = 1'b1;
                    state_d        = S_IDLE;
                    if (aeoi_mode && !spur_q) begin
                        aeoi_clr[lvl_q] = 1'b1;
`ifdef PIC_ROTATE_EN
                        if (rot_aeoi_q) prio_base_d = lvl_q + 3'd1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ocw2_valid) begin
            case (ocw2_cmd)
                3'b001: if (isr_hit[3]) ocw_clr[hp_isr_lvl] = 1'b1;
                3'b011: ocw_clr[ocw2_level] = 1'b1;
`ifdef PIC_ROTATE_EN
                3'b101: begin
                    if (isr_hit[3]) begin
                        ocw_clr[hp_isr_lvl] = 1'b1;
                        prio_base_d         = hp_isr_lvl + 3'd1;
                    end
                end
                3'b111: begin
                    if (isr_q[ocw2_level]) begin
                        ocw_clr[ocw2_level] = 1'b1;
                        prio_base_d         = ocw2_level + 3'd1;
                    end
                end
                3'b110: prio_base_d = ocw2_level + 3'd1;
                3'b100: rot_aeoi_d  = 1'b1;
                3'b000: rot_aeoi_d  = 1'b0;
`else
                3'b101: if (isr_hit[3]) ocw_clr[hp_isr_lvl] = 1'b1;
                3'b111: ocw_clr[ocw2_level] = 1'b1;
`endif
                default: ;
            endcase
        end

        // Set first, then all clears, so a same-edge OCW2 clear still sees the old ISR view.
        isr_d = (isr_q | set_mask) & ~(aeoi_clr | ocw_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            int_out_q      <= 1'b0;
            irr_clear_q    <= '0;
            isr_q          <= '0;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
            lvl_q          <= '0;
            spur_q         <= 1'b0;
`ifdef PIC_ROTATE_EN
            prio_base_q    <= '0;
            rot_aeoi_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            int_out_q      <= int_out_d;
            irr_clear_q    <= irr_clear_d;
            isr_q          <= isr_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
            lvl_q          <= lvl_d;
            spur_q         <= spur_d;
`ifdef PIC_ROTATE_EN
            prio_base_q    <= prio_base_d;
            rot_aeoi_q     <= rot_aeoi_d;
`endif
        end
    end

    assign int_out      = int_out_q;
    assign irr_clear    = irr_clear_q;
    assign isr          = isr_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;
    assign prio_base    = base;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed table-driven bench for pic_inta_sequencer; rotation expectations follow PIC_ROTATE_EN.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_pend;
    logic       inta_pulse;
    logic       aeoi_mode;
    logic [4:0] vec_base;
    logic       ocw2_valid;
    logic [2:0] ocw2_cmd;
    logic [2:0] ocw2_level;
    logic       int_out;
    logic [7:0] irr_clear;
    logic [7:0] isr;
    logic [7:0] vector;
    logic       vector_valid;
    logic [2:0] prio_base;

    int checks   = 0;
    int failures = 0;

    pic_inta_sequencer #(.NUM_IR(8), .SPUR_LEVEL(3'd7)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_pend     (irq_pend),
        .inta_pulse   (inta_pulse),
        .aeoi_mode    (aeoi_mode),
        .vec_base     (vec_base),
        .ocw2_valid   (ocw2_valid),
        .ocw2_cmd     (ocw2_cmd),
        .ocw2_level   (ocw2_level),
        .int_out      (int_out),
        .irr_clear    (irr_clear),
        .isr          (isr),
        .vector       (vector),
        .vector_valid (vector_valid),
        .prio_base    (prio_base)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] irq;
        logic       inta;
        logic       aeoi;
        logic       ov;
        logic [2:0] oc;
        logic [2:0] ol;
        logic       e_int;
        logic [7:0] e_irr;
        logic [7:0] e_isr;
        logic [7:0] e_vec;
        logic       e_vv;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] irq, input logic inta, input logic ov,
                         input logic [2:0] oc, input logic [2:0] ol);
        irq_pend   = irq;
        inta_pulse = inta;
        ocw2_valid = ov;
        ocw2_cmd   = oc;
        ocw2_level = ol;
    endtask

    initial begin
        logic       rot;
        logic [2:0] lvl6;
`ifdef PIC_ROTATE_EN
        rot = 1'b1;
`else
        rot = 1'b0;
`endif
        // name, irq, inta, aeoi, ocw_v, cmd, lvl | int, irr_clear, isr, vector, vector_valid
        tbl.push_back('{"req08",      8'h08, 1, 0, 0, 3'd0, 3'd0, 1, 8'h00, 8'h00, 8'h00, 0});
        tbl[0].inta = 1'b0;
        tbl.push_back('{"inta1",      8'h08, 1, 0, 0, 3'd0, 3'd0, 0, 8'h08, 8'h08, 8'h00, 0});
        tbl.push_back('{"ack1w",      8'h00, 0, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h08, 8'h00, 0});
        tbl.push_back('{"inta2",      8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h08, 8'h83, 1});
        tbl.push_back('{"hold",       8'h00, 0, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h08, 8'h83, 0});
        tbl.push_back('{"req22",      8'h22, 0, 0, 0, 3'd0, 3'd0, 1, 8'h00, 8'h08, 8'h83, 0});
        tbl.push_back('{"inta1_ir1",  8'h22, 1, 0, 0, 3'd0, 3'd0, 0, 8'h02, 8'h0A, 8'h83, 0});
        tbl.push_back('{"ack1_ir1",   8'h20, 0, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h0A, 8'h83, 0});
        tbl.push_back('{"inta2_ir1",  8'h20, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h0A, 8'h81, 1});
        tbl.push_back('{"ir5_blk",    8'h20, 0, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h0A, 8'h81, 0});
        tbl.push_back('{"eoi_ir1",    8'h20, 0, 0, 1, 3'd1, 3'd0, 0, 8'h00, 8'h08, 8'h81, 0});
        tbl.push_back('{"eoi_ir3",    8'h20, 0, 0, 1, 3'd1, 3'd0, 0, 8'h00, 8'h00, 8'h81, 0});
        tbl.push_back('{"req_ir5",    8'h20, 0, 0, 0, 3'd0, 3'd0, 1, 8'h00, 8'h00, 8'h81, 0});
        tbl.push_back('{"inta1_ir5",  8'h20, 1, 0, 0, 3'd0, 3'd0, 0, 8'h20, 8'h20, 8'h81, 0});
        tbl.push_back('{"ack1_ir5",   8'h00, 0, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h20, 8'h81, 0});
        tbl.push_back('{"inta2_ir5",  8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h20, 8'h85, 1});
        tbl.push_back('{"seoi5",      8'h00, 0, 0, 1, 3'd3, 3'd5, 0, 8'h00, 8'h00, 8'h85, 0});
        tbl.push_back('{"aeoi_req",   8'h01, 0, 1, 0, 3'd0, 3'd0, 1, 8'h00, 8'h00, 8'h85, 0});
        tbl.push_back('{"aeoi_inta1", 8'h01, 1, 1, 0, 3'd0, 3'd0, 0, 8'h01, 8'h01, 8'h85, 0});
        tbl.push_back('{"aeoi_ack1",  8'h00, 0, 1, 0, 3'd0, 3'd0, 0, 8'h00, 8'h01, 8'h85, 0});
        tbl.push_back('{"aeoi_inta2", 8'h00, 1, 1, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h80, 1});
        tbl.push_back('{"spur_req",   8'h04, 0, 0, 0, 3'd0, 3'd0, 1, 8'h00, 8'h00, 8'h80, 0});
        tbl.push_back('{"spur_inta1", 8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h80, 0});
        tbl.push_back('{"spur_ack1",  8'h00, 0, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h80, 0});
        tbl.push_back('{"spur_inta2", 8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h87, 1});
        tbl.push_back('{"idle_inta",  8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h87, 0});
        tbl.push_back('{"req10",      8'h10, 0, 0, 0, 3'd0, 3'd0, 1, 8'h00, 8'h00, 8'h87, 0});
        tbl.push_back('{"drop10",     8'h00, 0, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h87, 0});
        tbl.push_back('{"idle_inta2", 8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h87, 0});
        tbl.push_back('{"eoi_empty",  8'h00, 0, 0, 1, 3'd1, 3'd0, 0, 8'h00, 8'h00, 8'h87, 0});
        tbl.push_back('{"req08b",     8'h08, 0, 0, 0, 3'd0, 3'd0, 1, 8'h00, 8'h00, 8'h87, 0});
        tbl.push_back('{"inta1_08b",  8'h08, 1, 0, 0, 3'd0, 3'd0, 0, 8'h08, 8'h08, 8'h87, 0});
        tbl.push_back('{"ack1_08b",   8'h00, 0, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h08, 8'h87, 0});
        tbl.push_back('{"inta2_08b",  8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h08, 8'h83, 1});
        tbl.push_back('{"req02",      8'h02, 0, 0, 0, 3'd0, 3'd0, 1, 8'h00, 8'h08, 8'h83, 0});
        tbl.push_back('{"inta1_eoi",  8'h02, 1, 0, 1, 3'd1, 3'd0, 0, 8'h02, 8'h02, 8'h83, 0});
        tbl.push_back('{"ack1_02",    8'h00, 0, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h02, 8'h83, 0});
        tbl.push_back('{"inta2_02",   8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 8'h02, 8'h81, 1});
        tbl.push_back('{"seoi1",      8'h00, 0, 0, 1, 3'd3, 3'd1, 0, 8'h00, 8'h00, 8'h81, 0});

        rst_n     = 1'b0;
        aeoi_mode = 1'b0;
        vec_base  = 5'h10;
        drive(8'h00, 0, 0, 3'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_int", {7'd0, int_out}, 8'h00);
        chk("rst_irr", irr_clear, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_vec", vector, 8'h00);
        chk("rst_vv", {7'd0, vector_valid}, 8'h00);
        chk("rst_pb", {5'd0, prio_base}, 8'h00);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            aeoi_mode = tbl[k].aeoi;
            drive(tbl[k].irq, tbl[k].inta, tbl[k].ov, tbl[k].oc, tbl[k].ol);
            step();
            chk({tbl[k].name, ".int"}, {7'd0, int_out}, {7'd0, tbl[k].e_int});
            chk({tbl[k].name, ".irr"}, irr_clear, tbl[k].e_irr);
            chk({tbl[k].name, ".isr"}, isr, tbl[k].e_isr);
            chk({tbl[k].name, ".vec"}, vector, tbl[k].e_vec);
            chk({tbl[k].name, ".vv"}, {7'd0, vector_valid}, {7'd0, tbl[k].e_vv});
        end
        aeoi_mode = 1'b0;

        // Rotation: service IR4, rotate-on-nonspecific EOI, then IR6 vs IR0.
        drive(8'h10, 0, 0, 3'd0, 3'd0); step();
        chk("rot_req", {7'd0, int_out}, 8'h01);
        drive(8'h10, 1, 0, 3'd0, 3'd0); step();
        chk("rot_isr4", isr, 8'h10);
        drive(8'h00, 0, 0, 3'd0, 3'd0); step();
        drive(8'h00, 1, 0, 3'd0, 3'd0); step();
        drive(8'h00, 0, 1, 3'd5, 3'd0); step();
        chk("rot_eoi_isr", isr, 8'h00);
        chk("rot_eoi_pb", {5'd0, prio_base}, rot ? 8'h05 : 8'h00);
        drive(8'h41, 0, 0, 3'd0, 3'd0); step();
        chk("rot_req41", {7'd0, int_out}, 8'h01);
        drive(8'h41, 1, 0, 3'd0, 3'd0); step();
        chk("rot_win_irr", irr_clear, rot ? 8'h40 : 8'h01);
        drive(8'h00, 0, 0, 3'd0, 3'd0); step();
        drive(8'h00, 1, 0, 3'd0, 3'd0); step();
        chk("rot_win_vec", vector, rot ? 8'h86 : 8'h80);
        lvl6 = rot ? 3'd6 : 3'd0;
        drive(8'h00, 0, 1, 3'd3, lvl6); step();
        chk("rot_seoi", isr, 8'h00);
        drive(8'h00, 0, 1, 3'd6, 3'd2); step();
        chk("set_prio_pb", {5'd0, prio_base}, rot ? 8'h03 : 8'h00);
        drive(8'h00, 0, 1, 3'd6, 3'd7); step();
        chk("prio_wrap_pb", {5'd0, prio_base}, 8'h00);
        drive(8'h00, 0, 0, 3'd0, 3'd0);

        // Asynchronous reset while in ACK1.
        drive(8'h04, 0, 0, 3'd0, 3'd0); step();
        drive(8'h04, 1, 0, 3'd0, 3'd0); step();
        chk("pre_rst_isr", isr, 8'h04);
        drive(8'h00, 0, 0, 3'd0, 3'd0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_int", {7'd0, int_out}, 8'h00);
        chk("mid_rst_isr", isr, 8'h00);
        chk("mid_rst_irr", irr_clear, 8'h00);
        chk("mid_rst_vec", vector, 8'h00);
        rst_n = 1'b1;
        drive(8'h00, 1, 0, 3'd0, 3'd0); step();
        chk("post_rst_vv", {7'd0, vector_valid}, 8'h00);
        chk("post_rst_vec", vector, 8'h00);
        drive(8'h01, 0, 0, 3'd0, 3'd0); step();
        chk("post_rst_req", {7'd0, int_out}, 8'h01);
        drive(8'h01, 1, 0, 3'd0, 3'd0); step();
        chk("post_rst_isr", isr, 8'h01);
        chk("post_rst_irr", irr_clear, 8'h01);
        drive(8'h00, 0, 0, 3'd0, 3'd0); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
